// File: rtl/lfsr_crypto_pkg.sv
// Shared types for the chaotic-LFSR pixel crypto path (transmit encrypt and receive decrypt).
package lfsr_crypto_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] r;
    logic [DATA_W_DEFAULT-1:0] g;
    logic [DATA_W_DEFAULT-1:0] b;
  } rgb_t;

endpackage

// File: rtl/enc_out_stage.sv
// One-deep valid/ready output register for an encrypted pixel and its address.
module enc_out_stage
  import lfsr_crypto_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  rgb_t              data_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              out_ready,
  output logic              out_valid,
  output rgb_t              data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              slot_free
);

  logic              valid_r;
  rgb_t              data_r;
  logic [ADDR_W-1:0] addr_r;

  assign slot_free = !valid_r || out_ready;
  assign out_valid = valid_r;
  assign data_out  = data_r;
  assign addr_out  = addr_r;

  // Output register: reload on load, clear on drain, otherwise hold stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      data_r  <= '{r: 8'h00, g: 8'h00, b: 8'h00};
      addr_r  <= {ADDR_W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= data_in;
      addr_r  <= addr_in;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/pixel_encryptor.sv
// Transmit-side pixel encryptor: XORs each RGB pixel with one keystream triple and
// emits the result tagged with its pixel index; one run covers NUM_PIXELS pixels.
module pixel_encryptor
  import lfsr_crypto_pkg::*;
#(
  parameter int NUM_PIXELS = 16384,
  parameter int DATA_W     = lfsr_crypto_pkg::DATA_W_DEFAULT,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] R_plain,
  input  logic [DATA_W-1:0] G_plain,
  input  logic [DATA_W-1:0] B_plain,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [DATA_W-1:0] R_random,
  input  logic [DATA_W-1:0] G_random,
  input  logic [DATA_W-1:0] B_random,
  output logic              enc_valid,
  input  logic              enc_ready,
  output logic [DATA_W-1:0] R_enc,
  output logic [DATA_W-1:0] G_enc,
  output logic [DATA_W-1:0] B_enc,
  output logic [ADDR_W-1:0] enc_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   CNT_LIMIT = (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [ADDR_W:0] pix_cnt_r;
  logic            busy_r;
  logic            done_r;
  logic            slot_free_s;
  logic            fire_s;
  logic            restart_s;
  logic            last_hs_s;
  rgb_t            xor_s;
  rgb_t            enc_data_s;

  // Plaintext and keystream are consumed together, never one without the other.
  assign fire_s    = (state_r == RUN) && pix_valid && key_valid && slot_free_s
                     && (pix_cnt_r < CNT_LIMIT);
  assign pix_ready = fire_s;
  assign key_ready = fire_s;
  assign restart_s = start && (state_r != RUN);
  assign last_hs_s = (state_r == RUN) && enc_valid && enc_ready && (enc_addr == LAST_ADDR);

  assign xor_s.r = R_plain ^ R_random;
  assign xor_s.g = G_plain ^ G_random;
  assign xor_s.b = B_plain ^ B_random;

  enc_out_stage #(.ADDR_W(ADDR_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (fire_s),
    .data_in   (xor_s),
    .addr_in   (pix_cnt_r[ADDR_W-1:0]),
    .out_ready (enc_ready),
    .out_valid (enc_valid),
    .data_out  (enc_data_s),
    .addr_out  (enc_addr),
    .slot_free (slot_free_s)
  );

  assign R_enc = enc_data_s.r;
  assign G_enc = enc_data_s.g;
  assign B_enc = enc_data_s.b;
  assign busy  = busy_r;
  assign done  = done_r;

  // Next-state decode; start only takes effect outside RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_hs_s) state_nxt_s = DONE;
        else           state_nxt_s = RUN;
      end
      DONE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, pixel counter and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      pix_cnt_r <= {(ADDR_W+1){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
      if (restart_s) begin
        pix_cnt_r <= {(ADDR_W+1){1'b0}};
      end else if (fire_s) begin
        pix_cnt_r <= pix_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        pix_cnt_r <= pix_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pixel_encryptor.sv
// Randomized self-checking bench for pixel_encryptor against a queue-based reference model.
module tb_pixel_encryptor;

  localparam int N  = 16;
  localparam int AW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pix_valid = 1'b0, key_valid = 1'b0, enc_ready = 1'b0;
  logic [7:0] R_plain = 8'h00, G_plain = 8'h00, B_plain = 8'h00;
  logic [7:0] R_random = 8'h00, G_random = 8'h00, B_random = 8'h00;
  logic       pix_ready, key_ready, enc_valid, busy, done;
  logic [7:0] R_enc, G_enc, B_enc;
  logic [AW-1:0] enc_addr;

  pixel_encryptor #(.NUM_PIXELS(N), .DATA_W(8), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .R_plain(R_plain), .G_plain(G_plain), .B_plain(B_plain),
    .key_valid(key_valid), .key_ready(key_ready),
    .R_random(R_random), .G_random(G_random), .B_random(B_random),
    .enc_valid(enc_valid), .enc_ready(enc_ready),
    .R_enc(R_enc), .G_enc(G_enc), .B_enc(B_enc), .enc_addr(enc_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, g, b, a;
  } exp_t;

  exp_t q[$];
  bit   m_run = 1'b0, m_done = 1'b0;
  int   issued = 0;
  int   vectors = 0, miscompares = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance the model.
  task automatic step(input bit st, input bit pv, input bit kv, input bit er,
                      input logic [7:0] rp, input logic [7:0] gp, input logic [7:0] bp,
                      input logic [7:0] rk, input logic [7:0] gk, input logic [7:0] bk);
    bit   exp_rdy, run_pre;
    exp_t e;
    start = st; pix_valid = pv; key_valid = kv; enc_ready = er;
    R_plain = rp; G_plain = gp; B_plain = bp;
    R_random = rk; G_random = gk; B_random = bk;
    @(negedge clk);
    exp_rdy = m_run && pv && kv && (q.size() == 0 || er) && (issued < N);
    check_val("pix_ready", int'(pix_ready), int'(exp_rdy));
    check_val("key_ready", int'(key_ready), int'(exp_rdy));
    check_val("enc_valid", int'(enc_valid), int'(q.size() != 0));
    check_val("busy", int'(busy), int'(m_run));
    check_val("done", int'(done), int'(m_done));
    if (q.size() != 0) begin
      check_val("R_enc", int'(R_enc), q[0].r);
      check_val("G_enc", int'(G_enc), q[0].g);
      check_val("B_enc", int'(B_enc), q[0].b);
      check_val("enc_addr", int'(enc_addr), q[0].a);
    end
    run_pre = m_run;
    if (q.size() != 0 && er) begin
      if (q[0].a == N - 1) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
      void'(q.pop_front());
    end
    if (exp_rdy) begin
      e.r = int'(rp) ^ int'(rk);
      e.g = int'(gp) ^ int'(gk);
      e.b = int'(bp) ^ int'(bk);
      e.a = issued;
      q.push_back(e);
      issued++;
    end
    if (st && !run_pre) begin
      m_run  = 1'b1;
      m_done = 1'b0;
      issued = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic rand_step(input bit st, input bit er_always);
    step(st, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
         er_always || ($urandom_range(0, 2) != 0),
         8'($urandom), 8'($urandom), 8'($urandom),
         8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check_val("rst_enc_valid", int'(enc_valid), 0);
    check_val("rst_R_enc", int'(R_enc), 0);
    check_val("rst_G_enc", int'(G_enc), 0);
    check_val("rst_B_enc", int'(B_enc), 0);
    check_val("rst_enc_addr", int'(enc_addr), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_pix_ready", int'(pix_ready), 0);
    check_val("rst_key_ready", int'(key_ready), 0);
    q.delete();
    m_run = 1'b0; m_done = 1'b0; issued = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input string tag);
    int cyc = 0;
    while (!m_done && cyc < 500) begin
      rand_step(1'b0, 1'b0);
      cyc++;
    end
    check_val(tag, int'(m_done), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset then idle: valids high, no start, nothing consumed.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    async_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);

    // Single pixel XOR with fixed values.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'hFF, 8'h5A, 8'h3C, 8'h0F);
    check_val("xor_R", int'(R_enc), 32'hFF);
    check_val("xor_G", int'(G_enc), 32'h00);
    check_val("xor_B", int'(B_enc), 32'hF0);
    check_val("xor_addr", int'(enc_addr), 0);

    // Back-pressure: output held, nothing fires.
    for (int i = 0; i < 5; i++) rand_step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom));

    // Keystream stall.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 8'h88, 8'h99, 8'h00, 8'h00, 8'h00);

    run_until_done("run1_complete");
    // Extra input after the last pixel is ignored; done holds.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);

    // Restart from DONE with random gaps for a full run.
    rand_step(1'b1, 1'b0);
    run_until_done("run2_complete");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F);

    // Restart, then reset mid-run at pixel 7.
    rand_step(1'b1, 1'b1);
    begin
      int cyc = 0;
      while (issued < 7 && cyc < 200) begin
        rand_step(1'b0, 1'b1);
        cyc++;
      end
      check_val("reach_pix7", issued, 7);
    end
    async_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'hA5);

    // Final fresh run after the reset.
    rand_step(1'b1, 1'b0);
    run_until_done("run3_complete");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
